// File: rtl/wall_map.sv
// rtl/wall_map.sv - scrollable band of breakable brick tiles with hit handshake
// Optional horizontal scrolling is enabled by defining WALL_SCROLL_EN.
module wall_map #(
  parameter int TILE        = 20,
  parameter int ROW_Y       = 400,
  parameter int ROWS        = 2,
  parameter int H_RES       = 640,
  parameter int SCROLL_STEP = 4
) (
  input  logic                                    Clk,
  input  logic                                    Reset_n,
  input  logic                                    frame_clk,
  input  logic [9:0]                              DrawX,
  input  logic [9:0]                              DrawY,
  input  logic                                    hit_valid,
  input  logic [9:0]                              hit_x,
  input  logic [9:0]                              hit_y,
  output logic                                    hit_ready,
  output logic                                    hit_done,
  output logic                                    hit_result,
  output logic                                    wall,
  output logic                                    brick,
  output logic [$clog2(TILE*TILE)-1:0]            wall_pic_addr,
  output logic [$clog2(ROWS*(H_RES/TILE)+1)-1:0]  bricks_left
);

  localparam int COLS = H_RES / TILE;
  localparam int NB   = ROWS * COLS;
  localparam int AW   = $clog2(TILE * TILE);
  localparam int CW   = $clog2(NB + 1);
  localparam int IW   = (NB > 1) ? $clog2(NB) : 1;

  typedef struct packed {
    logic          in_band;
    logic [IW-1:0] idx;
    logic [AW-1:0] addr;
  } pt_t;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RESP} state_t;

  // Shared by the pixel path and the hit path so both resolve a point identically.
  function automatic pt_t map_pt(input logic [9:0] x, input logic [9:0] y, input logic [9:0] sc);
    logic [10:0] s;
    logic [9:0]  dy;
    int          col, row, xo, yo;
    pt_t         p;
    s = {1'b0, x} + {1'b0, sc};
    if (s >= 11'(H_RES)) s = s - 11'(H_RES);
    dy  = y - 10'(ROW_Y);
    col = int'(s) / TILE;
    xo  = int'(s) % TILE;
    row = int'(dy) / TILE;
    yo  = int'(dy) % TILE;
    p.in_band = ({1'b0, x} < 11'(H_RES)) && ({1'b0, y} >= 11'(ROW_Y)) &&
                ({1'b0, y} < 11'(ROW_Y + ROWS * TILE));
    p.idx  = p.in_band ? IW'(row * COLS + col) : '0;
    p.addr = p.in_band ? AW'(xo + yo * TILE) : '0;
    return p;
  endfunction

  logic [9:0] scroll;

`ifdef WALL_SCROLL_EN
  logic        frame_q;
  logic [10:0] scroll_sum;

  assign scroll_sum = {1'b0, scroll} + 11'(SCROLL_STEP);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_q <= 1'b0;
      scroll  <= '0;
    end else begin
      frame_q <= frame_clk;
      if (frame_clk && !frame_q)
        scroll <= (scroll_sum >= 11'(H_RES)) ? 10'(scroll_sum - 11'(H_RES)) : scroll_sum[9:0];
    end
  end
`else
  logic unused_frame;
  assign scroll       = '0;
  assign unused_frame = frame_clk;
`endif

  logic [NB-1:0] bmap;
  state_t        state;
  logic [9:0]    hx, hy, hs;
  logic          res;
  logic          ready_q;
  pt_t           hp, pp;

  assign hp = map_pt(hx, hy, hs);
  assign pp = map_pt(DrawX, DrawY, scroll);

  // ready_q resets high so the port is 1 as soon as reset releases.
  assign hit_ready = ready_q & Reset_n;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_IDLE;
      bmap        <= '1;
      bricks_left <= CW'(NB);
      hx          <= '0;
      hy          <= '0;
      hs          <= '0;
      res         <= 1'b0;
      ready_q     <= 1'b1;
      hit_done    <= 1'b0;
      hit_result  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          hit_done   <= 1'b0;
          hit_result <= 1'b0;
          ready_q    <= 1'b1;
          if (hit_valid && ready_q) begin
            hx      <= hit_x;
            hy      <= hit_y;
            hs      <= scroll;
            ready_q <= 1'b0;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (hp.in_band && bmap[hp.idx] && (bricks_left != '0)) begin
            bmap[hp.idx] <= 1'b0;
            bricks_left  <= bricks_left - CW'(1);
            res          <= 1'b1;
          end else begin
            res <= 1'b0;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          hit_done   <= 1'b1;
          hit_result <= res;
          ready_q    <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wall          <= 1'b0;
      brick         <= 1'b0;
      wall_pic_addr <= '0;
    end else begin
      wall          <= pp.in_band;
      brick         <= pp.in_band & bmap[pp.idx];
      wall_pic_addr <= pp.addr;
    end
  end

endmodule

// File: tb/tb_wall_map.sv
// tb/tb_wall_map.sv - scoreboard bench for wall_map (pixel path, hit handshake, reset, scroll)
module tb_wall_map;
  localparam int TILE = 20, ROW_Y = 400, ROWS = 2, H_RES = 640, STEP = 4;
  localparam int COLS = H_RES / TILE;
  localparam int NB   = ROWS * COLS;

  logic       clk = 0, rst_n = 1, frame_clk = 0;
  logic [9:0] draw_x = 0, draw_y = 0, hit_x = 0, hit_y = 0;
  logic       hit_valid = 0;
  logic       hit_ready, hit_done, hit_result, wall, brick;
  logic [8:0] wall_pic_addr;
  logic [6:0] bricks_left;

  wall_map #(.TILE(TILE), .ROW_Y(ROW_Y), .ROWS(ROWS), .H_RES(H_RES), .SCROLL_STEP(STEP)) dut (
    .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk), .DrawX(draw_x), .DrawY(draw_y),
    .hit_valid(hit_valid), .hit_x(hit_x), .hit_y(hit_y), .hit_ready(hit_ready),
    .hit_done(hit_done), .hit_result(hit_result), .wall(wall), .brick(brick),
    .wall_pic_addr(wall_pic_addr), .bricks_left(bricks_left)
  );

  always #5 clk = ~clk;

  typedef struct { int res; int cnt; int acc; } hit_e;
  typedef struct { int w; int b; int a; } pix_e;

  hit_e      sbq[$];
  pix_e      pixq[$];
  hit_e      he;
  logic [NB-1:0] mmap = '1;
  int        mcnt = NB, msc = 0;
  int        n_cmp = 0, n_err = 0, cyc = 0, n_done = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (hit_done) begin
      n_done++;
      if (sbq.size() == 0) chk("spurious_done", 1, 0);
      else begin
        he = sbq.pop_front();
        chk("hit_result", hit_result, he.res);
        chk("hit_count", bricks_left, he.cnt);
        chk("hit_latency", cyc - he.acc, 2);
      end
    end
  end

  // Called at the negedge before the accepting edge.
  task automatic model_push(input int x, input int y);
    int xe, idx, r;
    hit_e e;
    r = 0;
    if (x < H_RES && y >= ROW_Y && y < ROW_Y + ROWS * TILE) begin
      xe  = (x + msc) % H_RES;
      idx = ((y - ROW_Y) / TILE) * COLS + xe / TILE;
      if (mmap[idx]) begin
        mmap[idx] = 1'b0;
        mcnt--;
        r = 1;
      end
    end
    e.res = r; e.cnt = mcnt; e.acc = cyc + 1;
    sbq.push_back(e);
  endtask

  task automatic pix(input int x, input int y);
    pix_e e;
    int xe;
    @(negedge clk);
    draw_x = 10'(x); draw_y = 10'(y);
    e.w = (x < H_RES && y >= ROW_Y && y < ROW_Y + ROWS * TILE) ? 1 : 0;
    xe  = (x + msc) % H_RES;
    e.b = e.w ? int'(mmap[((y - ROW_Y) / TILE) * COLS + xe / TILE]) : 0;
    e.a = e.w ? (xe % TILE + ((y - ROW_Y) % TILE) * TILE) : 0;
    pixq.push_back(e);
    @(posedge clk); #1;
    e = pixq.pop_front();
    chk("pix_wall", wall, e.w);
    chk("pix_brick", brick, e.b);
    chk("pix_addr", wall_pic_addr, e.a);
  endtask

  task automatic do_hit(input int x, input int y);
    int b;
    @(negedge clk);
    hit_x = 10'(x); hit_y = 10'(y); hit_valid = 1;
    b = 0;
    while (!hit_ready && b < 20) begin @(negedge clk); b++; end
    if (!hit_ready) chk("ready_timeout", 0, 1);
    model_push(x, y);
    @(posedge clk); #1;
    hit_valid = 0;
    chk("ready_in_check", hit_ready, 0);
    @(posedge clk); #1;
    chk("count_at_t1", bricks_left, mcnt);
    repeat (3) @(posedge clk);
    #2;
    chk("hit_drained", sbq.size(), 0);
  endtask

  task automatic frame_pulse();
    @(negedge clk); frame_clk = 1;
    @(negedge clk); frame_clk = 0;
`ifdef WALL_SCROLL_EN
    msc = (msc + STEP) % H_RES;
`endif
  endtask

  initial begin
    int na, took, w, done0;
    int acc_at[3];
    #2 rst_n = 0;
    draw_x = 45; draw_y = 405;
    #20;
    chk("rst_ready", hit_ready, 0);
    chk("rst_done", hit_done, 0);
    chk("rst_wall", wall, 0);
    chk("rst_addr", wall_pic_addr, 0);
    chk("rst_count", bricks_left, NB);
    @(negedge clk); rst_n = 1; #1;
    chk("ready_after_rst", hit_ready, 1);
    pix(45, 405);
    chk("addr_45_405", wall_pic_addr, 105);

    do_hit(45, 425);
    chk("count_after_hit", bricks_left, 63);
    pix(45, 425);
    pix(44, 425);
    do_hit(45, 425);
    do_hit(45, 399);
    chk("count_unchanged", bricks_left, 63);
    pix(0, 400);
    pix(639, 439);
    pix(639, 440);
    pix(640, 420);
    pix(19, 419);
    do_hit(700, 420);

`ifdef WALL_SCROLL_EN
    repeat (3) frame_pulse();
    pix(630, 400);
    chk("addr_scroll12", wall_pic_addr, 2);
    repeat (157) frame_pulse();
    pix(45, 405);
    chk("addr_wrap", wall_pic_addr, 105);
    @(negedge clk); frame_clk = 1;
    repeat (6) @(negedge clk);
    frame_clk = 0;
    msc = (msc + STEP) % H_RES;
    pix(630, 410);
    do_hit(630, 410);
`endif

    // Back-to-back accepts with hit_valid held, frame tick during the first CHECK.
    @(negedge clk); hit_x = 100; hit_y = 405; hit_valid = 1;
    na = 0;
    for (int c = 0; c < 15 && na < 3; c++) begin
      took = 0;
      if (hit_ready) begin
        model_push(hit_x, hit_y);
        acc_at[na] = cyc + 1;
        na++;
        took = 1;
      end
      @(posedge clk); #1;
      if (took) begin
        chk("burst_ready_low", hit_ready, 0);
        if (na == 1) begin
          frame_clk = 1;
`ifdef WALL_SCROLL_EN
          msc = (msc + STEP) % H_RES;
`endif
        end
        hit_x = 10'(100 + 120 * na);
        if (na == 3) hit_valid = 0;
      end else frame_clk = 0;
      @(negedge clk);
    end
    frame_clk = 0;
    chk("burst_accepts", na, 3);
    chk("burst_spacing1", acc_at[1] - acc_at[0], 3);
    chk("burst_spacing2", acc_at[2] - acc_at[1], 3);
    w = 0;
    while (sbq.size() != 0 && w < 20) begin @(posedge clk); w++; end
    #2;
    chk("burst_drain", sbq.size(), 0);
    pix(100, 405);

    // Reset while the FSM sits in CHECK.
    @(negedge clk); hit_x = 145; hit_y = 425; hit_valid = 1;
    @(posedge clk); #1;
    hit_valid = 0;
    chk("mid_ready", hit_ready, 0);
    rst_n = 0; #1;
    done0 = n_done;
    chk("mid_rst_ready", hit_ready, 0);
    chk("mid_rst_done", hit_done, 0);
    chk("mid_rst_count", bricks_left, NB);
    chk("mid_rst_wall", wall, 0);
    mmap = '1; mcnt = NB; msc = 0;
    repeat (3) @(negedge clk);
    rst_n = 1; #1;
    chk("post_rst_ready", hit_ready, 1);
    repeat (5) @(posedge clk);
    #2;
    chk("no_done_after_rst", n_done - done0, 0);
    chk("post_rst_count", bricks_left, NB);
    pix(45, 425);
    pix(145, 425);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
